// File: rtl/mvm_pkg.sv
// Shared types and default widths for the MVM transmit-side packetizer.
// Latency: n/a (types only).
// Backpressure: n/a.
package mvm_pkg;

    localparam int DATAW_DEF = 512;
    localparam int IDW_DEF   = 32;
    localparam int DESTW_DEF = 32;
    localparam int USERW_DEF = 75;
    localparam int LENW_DEF  = 9;
    localparam int FIFOD_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } pktz_state_t;

    typedef struct packed {
        logic [LENW_DEF-1:0]  len_m1;
        logic [IDW_DEF-1:0]   id;
        logic [DESTW_DEF-1:0] dest;
        logic [USERW_DEF-1:0] user;
    } pktz_cmd_t;

endpackage

// File: rtl/mvm_sync_fifo.sv
// Generic synchronous FIFO (WIDTH x DEPTH, DEPTH a power of two) with full/empty flags.
// Latency: a word pushed in cycle t is visible at the head from t+1; no fall-through.
// Backpressure: pushes while full and pops while empty are ignored.
module mvm_sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mvm_axis_packetizer.sv
// Builds AXI-Stream packets from commands plus a buffered data stream; MVM_PKTZ_STATS_EN enables pkt_count.
// Latency: command to first beat 2 cycles with data buffered; one beat per cycle in steady state.
// Backpressure: output register holds while tready low; in_ready drops when the data FIFO is full.
module mvm_axis_packetizer
    import mvm_pkg::*;
#(
    parameter int DATAW = DATAW_DEF,
    parameter int IDW   = IDW_DEF,
    parameter int DESTW = DESTW_DEF,
    parameter int USERW = USERW_DEF,
    parameter int LENW  = LENW_DEF,
    parameter int FIFOD = FIFOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LENW-1:0]  cmd_len_m1,
    input  logic [IDW-1:0]   cmd_id,
    input  logic [DESTW-1:0] cmd_dest,
    input  logic [USERW-1:0] cmd_user,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             axis_tx_tvalid,
    input  logic             axis_tx_tready,
    output logic [DATAW-1:0] axis_tx_tdata,
    output logic             axis_tx_tlast,
    output logic [IDW-1:0]   axis_tx_tid,
    output logic [DESTW-1:0] axis_tx_tdest,
    output logic [USERW-1:0] axis_tx_tuser,
    output logic [31:0]      pkt_count
);

    pktz_state_t      state;
    pktz_state_t      state_nxt;
    pktz_cmd_t        cmd_q;
    logic [LENW-1:0]  beat_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DATAW-1:0] fifo_rd_data;
    logic             pop;
    logic             last_pop;
    logic             cmd_fire;

    assign in_ready = !fifo_full && !rst;
    assign cmd_fire = cmd_valid && cmd_ready;
    assign last_pop = pop && (beat_cnt == cmd_q.len_m1);

    mvm_sync_fifo #(
        .WIDTH (DATAW),
        .DEPTH (FIFOD)
    ) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = SEND;
            SEND:    if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pop refills the output register whenever it is empty or being drained this cycle.
    always_comb begin
        cmd_ready = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE:    cmd_ready = !rst;
            SEND:    pop = !fifo_empty && (!axis_tx_tvalid || axis_tx_tready);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q    <= '0;
            beat_cnt <= '0;
        end else if (cmd_fire) begin
            cmd_q    <= '{len_m1: cmd_len_m1, id: cmd_id, dest: cmd_dest, user: cmd_user};
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            axis_tx_tvalid <= 1'b0;
            axis_tx_tdata  <= '0;
            axis_tx_tlast  <= 1'b0;
            axis_tx_tid    <= '0;
            axis_tx_tdest  <= '0;
            axis_tx_tuser  <= '0;
        end else if (pop) begin
            axis_tx_tvalid <= 1'b1;
            axis_tx_tdata  <= fifo_rd_data;
            axis_tx_tlast  <= last_pop;
            axis_tx_tid    <= cmd_q.id;
            axis_tx_tdest  <= cmd_q.dest;
            axis_tx_tuser  <= cmd_q.user;
        end else if (axis_tx_tready) begin
            axis_tx_tvalid <= 1'b0;
        end
    end

`ifdef MVM_PKTZ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (axis_tx_tvalid && axis_tx_tready && axis_tx_tlast) begin
            pkt_count <= pkt_count + 1'b1;
        end
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_mvm_axis_packetizer.sv
// Directed bench for mvm_axis_packetizer: reset, packet shape, backpressure, FIFO full,
// single-beat packets, reset mid-packet and the optional packet counter.
module tb_mvm_axis_packetizer;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [8:0]   cmd_len_m1;
    logic [31:0]  cmd_id;
    logic [31:0]  cmd_dest;
    logic [74:0]  cmd_user;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_data;
    logic         axis_tx_tvalid;
    logic         axis_tx_tready;
    logic [511:0] axis_tx_tdata;
    logic         axis_tx_tlast;
    logic [31:0]  axis_tx_tid;
    logic [31:0]  axis_tx_tdest;
    logic [74:0]  axis_tx_tuser;
    logic [31:0]  pkt_count;

`ifdef MVM_PKTZ_STATS_EN
    localparam logic [31:0] EXP_PKTS = 32'd3;
`else
    localparam logic [31:0] EXP_PKTS = 32'd0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [511:0] rx_data[$];
    bit           rx_last[$];
    logic [31:0]  rx_id[$];
    logic [31:0]  rx_dest[$];
    logic [74:0]  rx_user[$];
    int           rx_cyc[$];
    int           stall_err;
    bit           timed_out;

    mvm_axis_packetizer dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_len_m1     (cmd_len_m1),
        .cmd_id         (cmd_id),
        .cmd_dest       (cmd_dest),
        .cmd_user       (cmd_user),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .axis_tx_tvalid (axis_tx_tvalid),
        .axis_tx_tready (axis_tx_tready),
        .axis_tx_tdata  (axis_tx_tdata),
        .axis_tx_tlast  (axis_tx_tlast),
        .axis_tx_tid    (axis_tx_tid),
        .axis_tx_tdest  (axis_tx_tdest),
        .axis_tx_tuser  (axis_tx_tuser),
        .pkt_count      (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [511:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 512'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [8:0] len, input logic [31:0] id, input logic [31:0] dest,
                            input logic [74:0] user, output bit acc);
        cmd_valid  = 1'b1;
        cmd_len_m1 = len;
        cmd_id     = id;
        cmd_dest   = dest;
        cmd_user   = user;
        #1;
        acc = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
        rx_id.delete();
        rx_dest.delete();
        rx_user.delete();
        rx_cyc.delete();
    endtask

    // Records accepted beats; cycle 0 is the cycle the task is entered.
    task automatic collect(input int n, input bit toggle, input int max_cyc);
        int got = 0;
        int cyc = 0;
        bit prev_stall = 1'b0;
        logic [511:0] pd = '0;
        bit pl = 1'b0;
        bit drop_in;
        stall_err = 0;
        while (got < n && cyc < max_cyc) begin
            axis_tx_tready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (prev_stall && (!axis_tx_tvalid || axis_tx_tdata !== pd || axis_tx_tlast !== pl))
                stall_err++;
            if (axis_tx_tvalid && axis_tx_tready) begin
                rx_data.push_back(axis_tx_tdata);
                rx_last.push_back(axis_tx_tlast);
                rx_id.push_back(axis_tx_tid);
                rx_dest.push_back(axis_tx_tdest);
                rx_user.push_back(axis_tx_tuser);
                rx_cyc.push_back(cyc);
                got++;
            end
            prev_stall = axis_tx_tvalid && !axis_tx_tready;
            pd = axis_tx_tdata;
            pl = axis_tx_tlast;
            drop_in = in_valid && in_ready;
            tick();
            if (drop_in) in_valid = 1'b0;
            cyc++;
        end
        timed_out = (got < n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (axis_tx_tvalid !== 1'b0) $display("FAIL rst_tvalid got %0b want 0", axis_tx_tvalid); else n_pass++;
        n_checks++; if (axis_tx_tlast !== 1'b0) $display("FAIL rst_tlast got %0b want 0", axis_tx_tlast); else n_pass++;
        n_checks++; if (axis_tx_tdata !== 512'h0) $display("FAIL rst_tdata got %0h want 0", axis_tx_tdata); else n_pass++;
        n_checks++; if (axis_tx_tid !== 32'h0 || axis_tx_tdest !== 32'h0 || axis_tx_tuser !== 75'h0)
            $display("FAIL rst_sideband got %0h/%0h/%0h want 0/0/0", axis_tx_tid, axis_tx_tdest, axis_tx_tuser); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %0b want 0", cmd_ready); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b want 0", in_ready); else n_pass++;
        n_checks++; if (pkt_count !== 32'd0) $display("FAIL rst_pkt_count got %0d want 0", pkt_count); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL post_rst_cmd_ready got %0b want 1", cmd_ready); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_four_beat();
        bit acc;
        axis_tx_tready = 1'b1;
        push_words(512'hA0, 4);
        send_cmd(9'd3, 32'd7, 32'd2, 75'h5, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL four_cmd_acc got %0b want 1", acc); else n_pass++;
        n_checks++; if (axis_tx_tvalid !== 1'b0) $display("FAIL four_tvalid_c1 got %0b want 0", axis_tx_tvalid); else n_pass++;
        clear_rx();
        collect(4, 1'b0, 20);
        n_checks++; if (timed_out) $display("FAIL four_timeout got %0d beats want 4", rx_data.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rx_data[i] !== 512'hA0 + 512'(i)) $display("FAIL four_data[%0d] got %0h want %0h", i, rx_data[i], 512'hA0 + 512'(i)); else n_pass++;
            n_checks++; if (rx_last[i] !== (i == 3)) $display("FAIL four_last[%0d] got %0b want %0b", i, rx_last[i], (i == 3)); else n_pass++;
            n_checks++; if (rx_dest[i] !== 32'd2 || rx_user[i] !== 75'h5 || rx_id[i] !== 32'd7)
                $display("FAIL four_side[%0d] got %0h/%0h/%0h want 2/5/7", i, rx_dest[i], rx_user[i], rx_id[i]); else n_pass++;
            n_checks++; if (rx_cyc[i] !== 1 + i) $display("FAIL four_cycle[%0d] got %0d want %0d", i, rx_cyc[i], 1 + i); else n_pass++;
        end
        n_checks++; if (axis_tx_tvalid !== 1'b0) $display("FAIL four_tvalid_after got %0b want 0", axis_tx_tvalid); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit acc;
        axis_tx_tready = 1'b0;
        push_words(512'hB0, 8);
        send_cmd(9'd7, 32'h11, 32'd3, 75'h9, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL bp_cmd_acc got %0b want 1", acc); else n_pass++;
        clear_rx();
        collect(8, 1'b1, 60);
        n_checks++; if (timed_out) $display("FAIL bp_timeout got %0d beats want 8", rx_data.size()); else n_pass++;
        n_checks++; if (stall_err !== 0) $display("FAIL bp_stall_stable got %0d changes want 0", stall_err); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (rx_data[i] !== 512'hB0 + 512'(i)) $display("FAIL bp_data[%0d] got %0h want %0h", i, rx_data[i], 512'hB0 + 512'(i)); else n_pass++;
            n_checks++; if (rx_last[i] !== (i == 7)) $display("FAIL bp_last[%0d] got %0b want %0b", i, rx_last[i], (i == 7)); else n_pass++;
        end
        axis_tx_tready = 1'b1;
        tick();
        n_checks++; if (axis_tx_tvalid !== 1'b0) $display("FAIL bp_no_extra got %0b want 0", axis_tx_tvalid); else n_pass++;
    endtask

    task automatic test_fifo_full();
        bit acc;
        int low_cnt = 0;
        axis_tx_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 512'hC0 + 512'(i);
            if (!in_ready) low_cnt++;
            tick();
        end
        n_checks++; if (low_cnt !== 0) $display("FAIL full_early got %0d low cycles want 0", low_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %0b want 0", in_ready); else n_pass++;
        in_data = 512'hD0;
        tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_hold got %0b want 0", in_ready); else n_pass++;
        send_cmd(9'd16, 32'd4, 32'd5, 75'h6, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL full_cmd_acc got %0b want 1", acc); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_before_pop got %0b want 0", in_ready); else n_pass++;
        clear_rx();
        collect(17, 1'b0, 60);
        n_checks++; if (timed_out) $display("FAIL full_timeout got %0d beats want 17", rx_data.size()); else n_pass++;
        for (int i = 0; i < 17; i++) begin
            n_checks++; if (rx_data[i] !== 512'hC0 + 512'(i)) $display("FAIL full_data[%0d] got %0h want %0h", i, rx_data[i], 512'hC0 + 512'(i)); else n_pass++;
            n_checks++; if (rx_last[i] !== (i == 16)) $display("FAIL full_last[%0d] got %0b want %0b", i, rx_last[i], (i == 16)); else n_pass++;
        end
        n_checks++; if (in_valid !== 1'b0) $display("FAIL full_17th_taken got in_valid %0b want 0", in_valid); else n_pass++;
    endtask

    task automatic test_single_beat();
        bit acc;
        axis_tx_tready = 1'b1;
        push_words(512'hE5, 2);
        send_cmd(9'd0, 32'd1, 32'd1, 75'h1, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL single_cmd_acc got %0b want 1", acc); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL single_send_busy got %0b want 0", cmd_ready); else n_pass++;
        tick();
        n_checks++; if (axis_tx_tvalid !== 1'b1 || axis_tx_tlast !== 1'b1 || axis_tx_tdata !== 512'hE5)
            $display("FAIL single_beat got v%0b l%0b %0h want v1 l1 e5", axis_tx_tvalid, axis_tx_tlast, axis_tx_tdata); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL single_idle got %0b want 1", cmd_ready); else n_pass++;
        send_cmd(9'd0, 32'd2, 32'd2, 75'h2, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL single_next_acc got %0b want 1", acc); else n_pass++;
        n_checks++; if (axis_tx_tvalid !== 1'b0) $display("FAIL single_gap got %0b want 0", axis_tx_tvalid); else n_pass++;
        tick();
        n_checks++; if (axis_tx_tvalid !== 1'b1 || axis_tx_tlast !== 1'b1 || axis_tx_tdata !== 512'hE6 || axis_tx_tid !== 32'd2)
            $display("FAIL single_second got v%0b l%0b %0h id%0h want v1 l1 e6 id2", axis_tx_tvalid, axis_tx_tlast, axis_tx_tdata, axis_tx_tid); else n_pass++;
        tick();
        n_checks++; if (axis_tx_tvalid !== 1'b0) $display("FAIL single_done got %0b want 0", axis_tx_tvalid); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        bit acc;
        axis_tx_tready = 1'b1;
        push_words(512'hF0, 6);
        send_cmd(9'd5, 32'd3, 32'd3, 75'h3, acc);
        clear_rx();
        collect(2, 1'b0, 20);
        n_checks++; if (rx_data[0] !== 512'hF0 || rx_data[1] !== 512'hF1)
            $display("FAIL mid_first_beats got %0h,%0h want f0,f1", rx_data[0], rx_data[1]); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++; if (axis_tx_tvalid !== 1'b0 || axis_tx_tlast !== 1'b0)
            $display("FAIL mid_rst_out got v%0b l%0b want v0 l0", axis_tx_tvalid, axis_tx_tlast); else n_pass++;
        n_checks++; if (in_ready !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL mid_rst_ready got in%0b cmd%0b want 0 0", in_ready, cmd_ready); else n_pass++;
        rst = 1'b0;
        repeat (3) tick();
        n_checks++; if (axis_tx_tvalid !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL mid_after got v%0b cmd%0b in%0b want 0 1 1", axis_tx_tvalid, cmd_ready, in_ready); else n_pass++;
        push_words(512'h11, 2);
        send_cmd(9'd1, 32'd9, 32'd9, 75'h9, acc);
        clear_rx();
        collect(2, 1'b0, 20);
        n_checks++; if (timed_out) $display("FAIL mid_new_timeout got %0d beats want 2", rx_data.size()); else n_pass++;
        n_checks++; if (rx_data[0] !== 512'h11 || rx_data[1] !== 512'h12)
            $display("FAIL mid_new_data got %0h,%0h want 11,12", rx_data[0], rx_data[1]); else n_pass++;
        n_checks++; if (rx_last[0] !== 1'b0 || rx_last[1] !== 1'b1)
            $display("FAIL mid_new_last got %0b,%0b want 0,1", rx_last[0], rx_last[1]); else n_pass++;
        tick();
        n_checks++; if (axis_tx_tvalid !== 1'b0) $display("FAIL mid_new_extra got %0b want 0", axis_tx_tvalid); else n_pass++;
    endtask

    task automatic test_stats();
        bit acc;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (pkt_count !== 32'd0) $display("FAIL stats_cleared got %0d want 0", pkt_count); else n_pass++;
        axis_tx_tready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            push_words(512'h30 + 512'(p), 1);
            send_cmd(9'd0, 32'(p), 32'd1, 75'h1, acc);
            clear_rx();
            collect(1, 1'b0, 10);
            n_checks++; if (rx_data[0] !== 512'h30 + 512'(p) || rx_last[0] !== 1'b1)
                $display("FAIL stats_pkt[%0d] got %0h l%0b want %0h l1", p, rx_data[0], rx_last[0], 512'h30 + 512'(p)); else n_pass++;
        end
        tick();
        n_checks++; if (pkt_count !== EXP_PKTS) $display("FAIL stats_count got %0d want %0d", pkt_count, EXP_PKTS); else n_pass++;
    endtask

    initial begin
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_len_m1     = '0;
        cmd_id         = '0;
        cmd_dest       = '0;
        cmd_user       = '0;
        in_valid       = 1'b0;
        in_data        = '0;
        axis_tx_tready = 1'b0;
        test_reset();
        test_four_beat();
        test_backpressure();
        test_fifo_full();
        test_single_beat();
        test_reset_mid_packet();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
